// File: rtl/spread_modulator_pkg.sv
// Shared constants, width helpers and sample type for the BPSK spread modulator.
package spread_modulator_pkg;

  localparam int PCODE_LEN     = 40920;
  localparam int MESSAGE_LEN   = 120;
  localparam int PCODE_REPEATS = 10;
  localparam int DAC_WIDTH     = 14;
  localparam int AMPLITUDE     = 8191;
  localparam int FRAME_CNT_W   = 16;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PCODE_AW = addr_w(PCODE_LEN);
  localparam int MSG_AW   = addr_w(MESSAGE_LEN);

  typedef logic signed [DAC_WIDTH-1:0] dac_sample_t;

endpackage

// File: rtl/spread_modulator_msg_double_buffer.sv
// Pending/active message buffers with host write handshake and frame-start swap.
module msg_double_buffer
  import spread_modulator_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [MESSAGE_LEN-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   swap,
  output logic [MESSAGE_LEN-1:0] active_word,
  output logic                   msg_repeat
);

  logic [MESSAGE_LEN-1:0] active_q;
  logic [MESSAGE_LEN-1:0] pending_q;
  logic                   pending_full;
  logic                   pending_full_n;
  logic                   wr_accept;

  assign wr_accept = wr_valid && wr_ready;

  // A swap empties pending, but a write landing in the same cycle refills it.
  always_comb begin
    pending_full_n = pending_full;
    if (swap)      pending_full_n = 1'b0;
    if (wr_accept) pending_full_n = 1'b1;
  end

  // Bypass so the strobe that triggers the swap already reads the new frame.
  assign active_word = (swap && pending_full) ? pending_q : active_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q     <= '0;
      pending_q    <= '0;
      pending_full <= 1'b0;
      wr_ready     <= 1'b1;
      msg_repeat   <= 1'b0;
    end else begin
      if (swap) begin
        if (pending_full) active_q   <= pending_q;
        else              msg_repeat <= 1'b1;
      end
      if (wr_accept) pending_q <= wr_data;
      pending_full <= pending_full_n;
      wr_ready     <= !pending_full_n;
    end
  end

endmodule

// File: rtl/spread_modulator.sv
// Per-strobe P-code chip XOR navigation bit, mapped to a signed BPSK DAC sample
// with a fixed two-cycle latency.
module spread_modulator
  import spread_modulator_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en,
  input  logic                   dac_valid,
  input  logic [PCODE_AW-1:0]    pcode_addr_i,
  input  logic [MSG_AW-1:0]      msg_addr_i,
  output logic                   rom_rd_o,
  output logic [PCODE_AW-1:0]    rom_addr_o,
  input  logic                   rom_data_i,
  input  logic                   msg_wr_valid,
  input  logic [MESSAGE_LEN-1:0] msg_wr_data,
  output logic                   msg_wr_ready,
  output logic [DAC_WIDTH-1:0]   dac_data_o,
  output logic                   dac_data_valid_o,
  output logic                   frame_start_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   msg_repeat_o,
  output logic                   addr_err_o
);

  localparam logic [MSG_AW:0] MSG_LIMIT = (MSG_AW+1)'(MESSAGE_LEN);
  localparam dac_sample_t     AMP_POS   = dac_sample_t'(AMPLITUDE);
  localparam dac_sample_t     AMP_NEG   = -AMP_POS;

  logic [MSG_AW-1:0]      prev_msg_addr;
  logic                   first_frame;
  logic                   frame_start;
  logic                   addr_ok;
  logic                   msg_bit_sel;
  logic [MESSAGE_LEN-1:0] active_word;

  logic s1_valid;
  logic s1_tx_en;
  logic s1_bit;

  assign rom_rd_o   = dac_valid;
  assign rom_addr_o = pcode_addr_i;

  // Address 0 held across repeated strobes counts as one start; any jump to 0 restarts.
  assign frame_start = dac_valid && (msg_addr_i == '0) &&
                       ((prev_msg_addr != '0) || first_frame);
  assign addr_ok     = {1'b0, msg_addr_i} < MSG_LIMIT;
  assign msg_bit_sel = addr_ok ? active_word[msg_addr_i] : 1'b0;

  msg_double_buffer u_msg_buf (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (msg_wr_valid),
    .wr_data     (msg_wr_data),
    .wr_ready    (msg_wr_ready),
    .swap        (frame_start),
    .active_word (active_word),
    .msg_repeat  (msg_repeat_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_msg_addr <= '0;
      first_frame   <= 1'b1;
      frame_cnt_o   <= '0;
      frame_start_o <= 1'b0;
      addr_err_o    <= 1'b0;
      s1_valid      <= 1'b0;
      s1_tx_en      <= 1'b0;
      s1_bit        <= 1'b0;
    end else begin
      s1_valid      <= dac_valid;
      frame_start_o <= frame_start;
      if (dac_valid) begin
        prev_msg_addr <= msg_addr_i;
        s1_tx_en      <= tx_en;
        s1_bit        <= msg_bit_sel;
        if (!addr_ok) addr_err_o <= 1'b1;
      end
      if (frame_start) begin
        first_frame <= 1'b0;
        frame_cnt_o <= frame_cnt_o + 1'b1;
      end
    end
  end

  // ROM data arrives alongside stage 1; sample holds between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_data_o       <= '0;
      dac_data_valid_o <= 1'b0;
    end else begin
      dac_data_valid_o <= s1_valid;
      if (s1_valid) begin
        if (!s1_tx_en)               dac_data_o <= '0;
        else if (rom_data_i ^ s1_bit) dac_data_o <= AMP_NEG;
        else                          dac_data_o <= AMP_POS;
      end
    end
  end

endmodule

// File: tb/tb_spread_modulator.sv
// Self-checking bench: directed scenarios plus random traffic against a frame-level model.
module tb_spread_modulator;
  import spread_modulator_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   tx_en;
  logic                   dac_valid;
  logic [PCODE_AW-1:0]    pcode_addr_i;
  logic [MSG_AW-1:0]      msg_addr_i;
  logic                   rom_rd_o;
  logic [PCODE_AW-1:0]    rom_addr_o;
  logic                   rom_data_i;
  logic                   msg_wr_valid;
  logic [MESSAGE_LEN-1:0] msg_wr_data;
  logic                   msg_wr_ready;
  logic signed [DAC_WIDTH-1:0] dac_data_o;
  logic                   dac_data_valid_o;
  logic                   frame_start_o;
  logic [FRAME_CNT_W-1:0] frame_cnt_o;
  logic                   msg_repeat_o;
  logic                   addr_err_o;

  spread_modulator dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .dac_valid(dac_valid),
    .pcode_addr_i(pcode_addr_i), .msg_addr_i(msg_addr_i),
    .rom_rd_o(rom_rd_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .msg_wr_valid(msg_wr_valid), .msg_wr_data(msg_wr_data), .msg_wr_ready(msg_wr_ready),
    .dac_data_o(dac_data_o), .dac_data_valid_o(dac_data_valid_o),
    .frame_start_o(frame_start_o), .frame_cnt_o(frame_cnt_o),
    .msg_repeat_o(msg_repeat_o), .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  // Code ROM: chips 0..3 read 0,1,0,1; above that a scrambled pattern.
  function automatic logic rom_bit(input int a);
    logic [31:0] x;
    logic [31:0] h;
    x = a;
    h = x * 32'h9E37_79B1;
    return x[0] ^ ((x >= 4) ? ^h[31:8] : 1'b0);
  endfunction

  always @(posedge clk)
    rom_data_i <= rom_rd_o ? rom_bit(int'(rom_addr_o)) : 1'($urandom);

  int tests = 0;
  int failed = 0;
  int nvalid = 0;
  int nfs = 0;

  logic [MESSAGE_LEN-1:0] m_active, m_pending;
  bit m_pfull, m_first, m_rep, m_err;
  int m_prev, m_cnt, m_last;
  bit p1_v, p2_v;
  int p1_d, p2_d;
  bit m_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_reset();
    m_active = '0; m_pending = '0; m_pfull = 0; m_first = 1;
    m_rep = 0; m_err = 0; m_prev = 0; m_cnt = 0; m_last = 0;
    p1_v = 0; p2_v = 0; p1_d = 0; p2_d = 0; m_fs = 0;
  endtask

  task automatic tick();
    int msg, d;
    bit rdy, b;
    msg = int'(msg_addr_i);
    rdy = !m_pfull;
    m_fs = 0;
    d = 0;
    chk("rom_rd", 32'(rom_rd_o), 32'(dac_valid));
    chk("rom_addr", 32'(rom_addr_o), 32'(pcode_addr_i));
    if (dac_valid) begin
      m_fs = (msg == 0) && (m_prev != 0 || m_first);
      m_prev = msg;
      if (m_fs) begin
        m_first = 0;
        m_cnt++;
        if (m_pfull) begin m_active = m_pending; m_pfull = 0; end
        else m_rep = 1;
      end
      b = (msg < MESSAGE_LEN) ? m_active[msg] : 1'b0;
      if (msg >= MESSAGE_LEN) m_err = 1;
      d = tx_en ? ((rom_bit(int'(pcode_addr_i)) ^ b) ? -AMPLITUDE : AMPLITUDE) : 0;
    end
    if (msg_wr_valid && rdy) begin m_pending = msg_wr_data; m_pfull = 1; end
    p2_v = p1_v; p2_d = p1_d;
    p1_v = dac_valid; p1_d = d;
    @(posedge clk); #1;
    if (p2_v) m_last = p2_d;
    chk("dac_valid", 32'(dac_data_valid_o), 32'(p2_v));
    chk("dac_data", int'(dac_data_o), m_last);
    chk("frame_start", 32'(frame_start_o), 32'(m_fs));
    chk("frame_cnt", 32'(frame_cnt_o), 32'(m_cnt[FRAME_CNT_W-1:0]));
    chk("msg_repeat", 32'(msg_repeat_o), 32'(m_rep));
    chk("addr_err", 32'(addr_err_o), 32'(m_err));
    chk("wr_ready", 32'(msg_wr_ready), 32'(!m_pfull));
    if (dac_data_valid_o) nvalid++;
    if (frame_start_o) nfs++;
    msg_wr_valid = 1'b0;
  endtask

  task automatic strobe(input int msg, input int pc, input bit tx);
    dac_valid = 1'b1;
    msg_addr_i = MSG_AW'(msg);
    pcode_addr_i = PCODE_AW'(pc);
    tx_en = tx;
    tick();
    dac_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      msg_addr_i = MSG_AW'($urandom_range(0, 127));
      pcode_addr_i = PCODE_AW'($urandom);
      tick();
    end
  endtask

  function automatic logic [MESSAGE_LEN-1:0] rand_frame();
    return MESSAGE_LEN'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    int c0, v0;
    rst = 1'b1; tx_en = 1'b0; dac_valid = 1'b0; pcode_addr_i = '0; msg_addr_i = '0;
    msg_wr_valid = 1'b0; msg_wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac", 32'(dac_data_o), 0);
    chk("rst_valid", 32'(dac_data_valid_o), 0);
    chk("rst_ready", 32'(msg_wr_ready), 1);
    chk("rst_cnt", 32'(frame_cnt_o), 0);
    rst = 1'b0;

    // Frame A load, then four strobes at bit 0
    msg_wr_valid = 1'b1; msg_wr_data = {15{8'hA5}};
    idle(1);
    for (int i = 0; i < 4; i++) strobe(0, i, 1);
    idle(2);
    chk("t1_cnt", 32'(frame_cnt_o), 1);
    chk("t1_fs_pulses", 32'(nfs), 1);
    chk("t1_last", int'(dac_data_o), AMPLITUDE);

    // 100 back-to-back strobes, no frame starts
    v0 = nvalid;
    for (int i = 0; i < 100; i++) strobe(1 + i, $urandom_range(0, PCODE_LEN - 1), 1);
    idle(2);
    chk("t2_pulses", 32'(nvalid - v0), 100);
    chk("t2_no_repeat", 32'(msg_repeat_o), 0);

    // Frame B written mid-frame, swap on 119 -> 0
    msg_wr_valid = 1'b1; msg_wr_data = rand_frame();
    strobe(60, 7, 1);
    chk("t3_ready_low", 32'(msg_wr_ready), 0);
    strobe(119, 8, 1);
    strobe(0, 9, 1);
    chk("t3_ready_after_swap", 32'(msg_wr_ready), 1);
    for (int i = 1; i < 6; i++) strobe(i, $urandom_range(0, PCODE_LEN - 1), 1);
    strobe(119, 11, 1);
    // Frame start with empty pending, write C in the same cycle
    msg_wr_valid = 1'b1; msg_wr_data = rand_frame();
    strobe(0, 12, 1);
    chk("t4_repeat", 32'(msg_repeat_o), 1);
    chk("t4_ready_low", 32'(msg_wr_ready), 0);
    strobe(1, 13, 1);

    // PPS restart, repeated bit 0, out-of-range address
    strobe(57, 14, 1);
    c0 = int'(frame_cnt_o);
    strobe(0, 15, 1);
    for (int i = 0; i < PCODE_REPEATS - 1; i++) strobe(0, 16 + i, 1);
    chk("t5_one_start", 32'(frame_cnt_o), 32'(c0 + 1));
    chk("t5_repeat_sticky", 32'(msg_repeat_o), 1);
    strobe(120, 30, 1);
    idle(2);
    chk("t5_addr_err", 32'(addr_err_o), 1);

    // tx_en low, then reset in the middle of a burst
    for (int i = 0; i < 20; i++) strobe($urandom_range(0, 119), $urandom_range(0, PCODE_LEN - 1), 0);
    for (int i = 0; i < 5; i++) strobe(i, i + 100, 1);
    dac_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rst_dac", 32'(dac_data_o), 0);
    chk("t6_rst_valid", 32'(dac_data_valid_o), 0);
    chk("t6_rst_err", 32'(addr_err_o), 0);
    chk("t6_rst_ready", 32'(msg_wr_ready), 1);
    dac_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    v0 = nvalid;
    idle(4);
    chk("t6_no_stale", 32'(nvalid - v0), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      msg_wr_valid = ($urandom_range(0, 4) == 0);
      msg_wr_data = rand_frame();
      if ($urandom_range(0, 9) < 7)
        strobe(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 121),
               $urandom_range(0, PCODE_LEN - 1), 1'($urandom));
      else
        idle(1);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
